imem_loader: RTL and testbench

- Write-side front end for the per-thread instruction memory. The fetch stage only reads that memory, so this block is what fills it.
- Accepts a byte stream over a valid/ready handshake and assembles the bytes into INSTR_WIDTH-bit little-endian words.
- Writes each word to address {thread_index, pc} through the memory's write port (waddr/wdata/we).
- Asserts a hold to keep the pipeline quiescent while a load is in progress.

---
 rtl/imem_loader_pkg.sv | 25 ++
 rtl/imem_loader_if.sv | 45 ++++
 rtl/imem_word_assembler.sv | 56 +++++
 rtl/imem_loader.sv | 146 ++++++++++++++
 tb/tb_imem_loader.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and sizing helpers for the instruction-memory loader.
// The optional checksum trailer is enabled with IMEM_LOADER_CHECKSUM_EN.
package imem_loader_pkg;

  localparam int PC_WIDTH_DEF          = 8;
  localparam int INSTR_WIDTH_DEF       = 32;
  localparam int THREAD_INDEX_BITS_DEF = 3;
  localparam int BYTES_PER_WORD        = INSTR_WIDTH_DEF / 8;

  // A one-byte word still needs a 1-bit counter to keep the vector legal.
  function automatic int byte_cnt_width(input int bytes_per_word);
    return (bytes_per_word > 1) ? $clog2(bytes_per_word) : 1;
  endfunction

  localparam int BYTE_CNT_WIDTH = byte_cnt_width(BYTES_PER_WORD);

  typedef enum logic [2:0] {
    IDLE,
    ASSEMBLE,
    WRITE,
    DONE,
    CHECK
  } imem_loader_state_t;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream, control and memory-write signals of the loader; master = host side.
// out_checksum_error exists only when IMEM_LOADER_CHECKSUM_EN is defined.
interface imem_loader_if
  import imem_loader_pkg::*;
#(
  parameter int PC_WIDTH          = PC_WIDTH_DEF,
  parameter int INSTR_WIDTH       = INSTR_WIDTH_DEF,
  parameter int THREAD_INDEX_BITS = THREAD_INDEX_BITS_DEF
) ();

  logic                                  in_start;
  logic [THREAD_INDEX_BITS-1:0]          in_thread_index;
  logic [PC_WIDTH-1:0]                   in_word_count;
  logic                                  in_byte_valid;
  logic [7:0]                            in_byte_data;
  logic                                  out_byte_ready;
  logic [THREAD_INDEX_BITS+PC_WIDTH-1:0] out_waddr;
  logic [INSTR_WIDTH-1:0]                out_wdata;
  logic                                  out_we;
  logic                                  out_busy;
  logic                                  out_hold_pipeline;
  logic                                  out_done;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic                                  out_checksum_error;
`endif

  modport master (
    output in_start, in_thread_index, in_word_count, in_byte_valid, in_byte_data,
    input  out_byte_ready, out_waddr, out_wdata, out_we, out_busy,
    input  out_hold_pipeline, out_done
`ifdef IMEM_LOADER_CHECKSUM_EN
    , input out_checksum_error
`endif
  );

  modport slave (
    input  in_start, in_thread_index, in_word_count, in_byte_valid, in_byte_data,
    output out_byte_ready, out_waddr, out_wdata, out_we, out_busy,
    output out_hold_pipeline, out_done
`ifdef IMEM_LOADER_CHECKSUM_EN
    , output out_checksum_error
`endif
  );

endinterface

// File: rtl/imem_word_assembler.sv
// Places incoming bytes little-endian into a word; word_d_o already includes
// the byte being transferred so the caller can capture a complete word on the last byte.
module imem_word_assembler
  import imem_loader_pkg::*;
#(
  parameter int INSTR_WIDTH = INSTR_WIDTH_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear_i,
  input  logic                   xfer_i,
  input  logic [7:0]             byte_i,
  output logic [INSTR_WIDTH-1:0] word_d_o,
  output logic                   word_done_o
);

  localparam int BPW = INSTR_WIDTH / 8;
  localparam int CW  = byte_cnt_width(BPW);

  logic [CW-1:0]          byte_cnt_q, byte_cnt_d;
  logic [INSTR_WIDTH-1:0] word_q;

  genvar gi;
  generate
    for (gi = 0; gi < BPW; gi++) begin : g_lane
      assign word_d_o[8*gi +: 8] = (xfer_i && (byte_cnt_q == CW'(gi))) ? byte_i
                                                                       : word_q[8*gi +: 8];
    end
  endgenerate

  assign word_done_o = xfer_i && (byte_cnt_q == CW'(BPW - 1));

  always_comb begin
    byte_cnt_d = byte_cnt_q;
    if (clear_i)
      byte_cnt_d = '0;
    else if (word_done_o)
      byte_cnt_d = '0;
    else if (xfer_i)
      byte_cnt_d = byte_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      byte_cnt_q <= '0;
      word_q     <= '0;
    end else begin
      byte_cnt_q <= byte_cnt_d;
      if (clear_i)
        word_q <= '0;
      else if (xfer_i)
        word_q <= word_d_o;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Loads a byte stream into a thread's instruction memory and holds the pipeline meanwhile.
// Define IMEM_LOADER_CHECKSUM_EN to require an XOR checksum word after the payload.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int PC_WIDTH          = PC_WIDTH_DEF,
  parameter int INSTR_WIDTH       = INSTR_WIDTH_DEF,
  parameter int THREAD_INDEX_BITS = THREAD_INDEX_BITS_DEF
) (
  input  logic        clk,
  input  logic        reset,
  imem_loader_if.slave bus
);

  imem_loader_state_t                    state_q;
  logic [THREAD_INDEX_BITS-1:0]          thread_q;
  logic [PC_WIDTH-1:0]                   count_q;
  logic [PC_WIDTH-1:0]                   wcnt_q;
  logic [PC_WIDTH-1:0]                   wcnt_d;
  logic [THREAD_INDEX_BITS+PC_WIDTH-1:0] waddr_q;
  logic [INSTR_WIDTH-1:0]                wdata_q;
  logic                                  we_q;
  logic                                  ready_q;
  logic                                  busy_q;
  logic                                  done_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [INSTR_WIDTH-1:0]                xor_q;
  logic                                  chk_err_q;
`endif

  logic                   start_accept;
  logic                   xfer;
  logic [INSTR_WIDTH-1:0] word_d;
  logic                   word_done;

  assign start_accept = (state_q == IDLE) && bus.in_start;
  assign xfer         = bus.in_byte_valid && ready_q;
  assign wcnt_d       = wcnt_q + 1'b1;

  imem_word_assembler #(
    .INSTR_WIDTH (INSTR_WIDTH)
  ) u_asm (
    .clk         (clk),
    .reset       (reset),
    .clear_i     (start_accept),
    .xfer_i      (xfer),
    .byte_i      (bus.in_byte_data),
    .word_d_o    (word_d),
    .word_done_o (word_done)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      thread_q  <= '0;
      count_q   <= '0;
      wcnt_q    <= '0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      xor_q     <= '0;
      chk_err_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_start) begin
            thread_q  <= bus.in_thread_index;
            count_q   <= bus.in_word_count;
            wcnt_q    <= '0;
            busy_q    <= 1'b1;
            ready_q   <= 1'b1;
            state_q   <= ASSEMBLE;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_q     <= '0;
            chk_err_q <= 1'b0;
`endif
          end
        end
        ASSEMBLE: begin
          if (word_done) begin
            ready_q <= 1'b0;
            we_q    <= 1'b1;
            wdata_q <= word_d;
            waddr_q <= {thread_q, wcnt_q};
            state_q <= WRITE;
          end
        end
        WRITE: begin
          we_q   <= 1'b0;
          wcnt_q <= wcnt_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
          xor_q  <= xor_q ^ wdata_q;
`endif
          // A latched count of 0 matches only after the counter wraps: 2^PC_WIDTH words.
          if (wcnt_d == count_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            ready_q <= 1'b1;
            state_q <= CHECK;
`else
            done_q  <= 1'b1;
            state_q <= DONE;
`endif
          end else begin
            ready_q <= 1'b1;
            state_q <= ASSEMBLE;
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        CHECK: begin
          if (word_done) begin
            ready_q   <= 1'b0;
            chk_err_q <= (word_d != xor_q);
            done_q    <= 1'b1;
            state_q   <= DONE;
          end
        end
`endif
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.out_byte_ready    = ready_q;
  assign bus.out_waddr         = waddr_q;
  assign bus.out_wdata         = wdata_q;
  assign bus.out_we            = we_q;
  assign bus.out_busy          = busy_q;
  assign bus.out_hold_pipeline = busy_q;
  assign bus.out_done          = done_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
  assign bus.out_checksum_error = chk_err_q;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: writes are checked against a scoreboard queue
// filled as each word is driven; control outputs are checked at fixed cycle points.
module tb_imem_loader;
  import imem_loader_pkg::*;

  localparam int PCW = 8;
  localparam int IW  = 32;
  localparam int TB  = 3;
  localparam int AW  = TB + PCW;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [IW-1:0] data;
  } wr_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;
  wr_t  exp_q[$];

  always #5 clk = ~clk;

  imem_loader_if #(.PC_WIDTH(PCW), .INSTR_WIDTH(IW), .THREAD_INDEX_BITS(TB)) bus ();

  imem_loader #(.PC_WIDTH(PCW), .INSTR_WIDTH(IW), .THREAD_INDEX_BITS(TB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Write monitor: every out_we cycle must match the oldest expected write.
  always @(negedge clk) begin
    if (bus.out_we === 1'b1) begin
      wr_t e;
      checks++;
      assert (exp_q.size() > 0) else begin
        errors++;
        $error("FAIL unexpected_write: observed addr 0x%0h data 0x%0h expected no write",
               bus.out_waddr, bus.out_wdata);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("wr_addr", 64'(bus.out_waddr), 64'(e.addr));
        check("wr_data", 64'(bus.out_wdata), 64'(e.data));
        check("ready_in_write", 64'(bus.out_byte_ready), 64'd0);
        check("hold_in_write", 64'(bus.out_hold_pipeline), 64'd1);
      end
    end
  end

  task automatic pulse_start(input logic [TB-1:0] thr, input logic [PCW-1:0] cnt);
    bus.in_start        = 1'b1;
    bus.in_thread_index = thr;
    bus.in_word_count   = cnt;
    @(negedge clk);
    bus.in_start        = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    while (bus.out_byte_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    assert (n < 50) else begin
      errors++;
      $error("FAIL ready_timeout: observed ready 0x%0h expected 0x1", bus.out_byte_ready);
    end
    bus.in_byte_valid = 1'b1;
    bus.in_byte_data  = b;
    @(negedge clk);
    bus.in_byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [IW-1:0] w, input int gap);
    for (int k = 0; k < IW / 8; k++) begin
      logic [IW-1:0] tmp;
      tmp = w >> (8 * k);
      send_byte(tmp[7:0]);
      if (k != IW / 8 - 1)
        repeat (gap) @(negedge clk);
    end
  endtask

  task automatic wait_done();
    int n = 0;
    while (bus.out_done !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", 64'(bus.out_done), 64'd1);
  endtask

  initial begin
    wr_t w;
    bus.in_start        = 1'b0;
    bus.in_thread_index = '0;
    bus.in_word_count   = '0;
    bus.in_byte_valid   = 1'b0;
    bus.in_byte_data    = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ready", 64'(bus.out_byte_ready), 64'd0);
    check("rst_we", 64'(bus.out_we), 64'd0);
    check("rst_busy", 64'(bus.out_busy), 64'd0);
    check("rst_done", 64'(bus.out_done), 64'd0);
    check("rst_waddr", 64'(bus.out_waddr), 64'd0);
    check("rst_wdata", 64'(bus.out_wdata), 64'd0);
    reset = 1'b1;
    @(negedge clk);

    // Single-word load, back-to-back bytes
    pulse_start(3'd3, 8'd1);
    check("busy_after_start", 64'(bus.out_busy), 64'd1);
    check("hold_after_start", 64'(bus.out_hold_pipeline), 64'd1);
    w.addr = 11'h300; w.data = 32'h12345678; exp_q.push_back(w);
    send_word(32'h12345678, 0);
    check("we_latency", 64'(bus.out_we), 64'd1);
    @(negedge clk);
    check("done_pulse", 64'(bus.out_done), 64'd1);
    check("busy_in_done", 64'(bus.out_busy), 64'd1);
    check("we_after_write", 64'(bus.out_we), 64'd0);
    @(negedge clk);
    check("done_one_cycle", 64'(bus.out_done), 64'd0);
    check("busy_cleared", 64'(bus.out_busy), 64'd0);
    check("hold_cleared", 64'(bus.out_hold_pipeline), 64'd0);
    check("wdata_held", 64'(bus.out_wdata), 64'h12345678);
    check("sb_empty_single", 64'(exp_q.size()), 64'd0);

    // Stalled stream: valid pattern 1,0,0,1
    pulse_start(3'd4, 8'd2);
    w.addr = 11'h400; w.data = 32'hDEADBEEF; exp_q.push_back(w);
    w.addr = 11'h401; w.data = 32'hCAFEF00D; exp_q.push_back(w);
    send_word(32'hDEADBEEF, 2);
    send_word(32'hCAFEF00D, 2);
    wait_done();
    @(negedge clk);
    check("sb_empty_stall", 64'(exp_q.size()), 64'd0);

    // Start while busy is ignored
    pulse_start(3'd2, 8'd2);
    w.addr = 11'h200; w.data = 32'h01020304; exp_q.push_back(w);
    w.addr = 11'h201; w.data = 32'hA0B0C0D0; exp_q.push_back(w);
    send_byte(8'h04);
    send_byte(8'h03);
    pulse_start(3'd1, 8'd5);
    send_byte(8'h02);
    send_byte(8'h01);
    send_word(32'hA0B0C0D0, 0);
    wait_done();
    @(negedge clk);
    check("sb_empty_busy_start", 64'(exp_q.size()), 64'd0);
    check("idle_after_busy_start", 64'(bus.out_busy), 64'd0);

    // Reset mid-load after 2 bytes of word 1
    pulse_start(3'd5, 8'd2);
    w.addr = 11'h500; w.data = 32'h11111111; exp_q.push_back(w);
    send_word(32'h11111111, 0);
    send_byte(8'h22);
    send_byte(8'h22);
    reset = 1'b0;
    #1;
    check("abort_ready", 64'(bus.out_byte_ready), 64'd0);
    check("abort_busy", 64'(bus.out_busy), 64'd0);
    check("abort_done", 64'(bus.out_done), 64'd0);
    check("abort_waddr", 64'(bus.out_waddr), 64'd0);
    check("abort_wdata", 64'(bus.out_wdata), 64'd0);
    check("sb_empty_abort", 64'(exp_q.size()), 64'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("no_done_after_abort", 64'(bus.out_done), 64'd0);
    pulse_start(3'd5, 8'd1);
    w.addr = 11'h500; w.data = 32'h33445566; exp_q.push_back(w);
    send_word(32'h33445566, 0);
    wait_done();
    @(negedge clk);
    check("sb_empty_reload", 64'(exp_q.size()), 64'd0);

    // Full thread: count 0 means 256 words
    pulse_start(3'd7, 8'd0);
    for (int i = 0; i < 256; i++) begin
      w.addr = 11'h700 + 11'(i); w.data = 32'(i); exp_q.push_back(w);
      send_word(32'(i), 0);
    end
    wait_done();
    check("full_last_wdata", 64'(bus.out_wdata), 64'h000000FF);
    check("full_last_waddr", 64'(bus.out_waddr), 64'h7FF);
    @(negedge clk);
    check("sb_empty_full", 64'(exp_q.size()), 64'd0);
    check("full_busy_cleared", 64'(bus.out_busy), 64'd0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Good checksum
    pulse_start(3'd6, 8'd2);
    w.addr = 11'h600; w.data = 32'hA5A5A5A5; exp_q.push_back(w);
    w.addr = 11'h601; w.data = 32'h0F0F0F0F; exp_q.push_back(w);
    send_word(32'hA5A5A5A5, 0);
    send_word(32'h0F0F0F0F, 0);
    send_word(32'hAAAAAAAA, 0);
    check("chk_ok_done", 64'(bus.out_done), 64'd1);
    check("chk_ok_flag", 64'(bus.out_checksum_error), 64'd0);
    @(negedge clk);
    check("sb_empty_chk_ok", 64'(exp_q.size()), 64'd0);

    // Bad checksum: flag set, never written
    pulse_start(3'd6, 8'd2);
    w.addr = 11'h600; w.data = 32'hA5A5A5A5; exp_q.push_back(w);
    w.addr = 11'h601; w.data = 32'h0F0F0F0F; exp_q.push_back(w);
    send_word(32'hA5A5A5A5, 0);
    send_word(32'h0F0F0F0F, 0);
    send_word(32'hAAAAAAAB, 0);
    check("chk_bad_done", 64'(bus.out_done), 64'd1);
    check("chk_bad_flag", 64'(bus.out_checksum_error), 64'd1);
    repeat (3) @(negedge clk);
    check("chk_bad_flag_held", 64'(bus.out_checksum_error), 64'd1);
    check("sb_empty_chk_bad", 64'(exp_q.size()), 64'd0);
    pulse_start(3'd0, 8'd1);
    check("chk_flag_cleared", 64'(bus.out_checksum_error), 64'd0);
    w.addr = 11'h000; w.data = 32'h55555555; exp_q.push_back(w);
    send_word(32'h55555555, 0);
    send_word(32'h55555555, 0);
    check("chk_single_flag", 64'(bus.out_checksum_error), 64'd0);
    @(negedge clk);
`endif

    repeat (3) @(negedge clk);
    check("sb_final_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
